// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate checker: FSM state encoding, expected
// function codes (func_sel) and the size of the exhaustive 2-input vector set.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FUNC_AND  = 2'b00,
    FUNC_OR   = 2'b01,
    FUNC_XOR  = 2'b10,
    FUNC_NAND = 2'b11
  } func_e;

  // Every {a,b} combination is applied once per run.
  localparam int unsigned NUM_VECS = 4;
  localparam int unsigned VEC_W    = 2;
  localparam int unsigned ERR_W    = 3;

endpackage

// File: rtl/gate_model.sv
// Combinational reference for a 2-input gate.
// Ports: func  - function code (AND/OR/XOR/NAND)
//        a, b  - gate inputs
//        y_exp - expected gate output
module gate_model
  import gate_chk_pkg::*;
(
  input  func_e func,
  input  logic  a,
  input  logic  b,
  output logic  y_exp
);

  always_comb begin
    y_exp = 1'b0;
    unique case (func)
      FUNC_AND:  y_exp = a & b;
      FUNC_OR:   y_exp = a | b;
      FUNC_XOR:  y_exp = a ^ b;
      FUNC_NAND: y_exp = ~(a & b);
      default:   y_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_checker.sv
// Exhaustive checker for an external 2-input gate. A run applies the vectors
// {a,b} = 00,01,10,11, holds each for SETTLE_CYCLES cycles, samples dut_y one
// cycle later and compares it with the expected function latched at start.
// Ports: clk, rst_n (async, active-low)
//        start, func_sel      - run request and expected function
//        dut_a, dut_b, dut_y  - stimulus to / response from the gate
//        busy, done           - status (done is a one-cycle pulse)
//        pass, err_cnt        - result of the last run
//        fail_vec, fail_valid - first mismatching vector
// All outputs come straight from flops; dut_y only reaches flop inputs.
module gate_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       func_sel,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [VEC_W-1:0] fail_vec,
  output logic             fail_valid
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(NUM_VECS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = ERR_W'(NUM_VECS);

  state_e             state_q, state_d;
  func_e              func_q, func_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [3:0]         settle_q, settle_d;
  logic               dut_a_q, dut_a_d;
  logic               dut_b_q, dut_b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [VEC_W-1:0]   fail_vec_q, fail_vec_d;
  logic               fail_valid_q, fail_valid_d;
  logic               y_exp;

  gate_model u_model (
    .func  (func_q),
    .a     (vec_q[1]),
    .b     (vec_q[0]),
    .y_exp (y_exp)
  );

  always_comb begin
    state_d      = state_q;
    func_d       = func_q;
    vec_d        = vec_q;
    settle_d     = settle_q;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    fail_vec_d   = fail_vec_q;
    fail_valid_d = fail_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          func_d       = func_e'(func_sel);
          vec_d        = '0;
          settle_d     = '0;
          pass_d       = 1'b0;
          err_cnt_d    = '0;
          fail_vec_d   = '0;
          fail_valid_d = 1'b0;
          state_d      = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (dut_y != y_exp) begin
          if (err_cnt_q < ERR_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
          if (!fail_valid_q) begin
            fail_vec_d   = vec_q;
            fail_valid_d = 1'b1;
          end
        end
        if (vec_q == VEC_LAST) begin
          // pass must include the mismatch of the final vector
          pass_d  = (err_cnt_d == '0);
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + VEC_W'(1);
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs are derived from the next state so they line up
    // with the state they describe.
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    dut_a_d = 1'b0;
    dut_b_d = 1'b0;
    if (state_d == ST_DRIVE || state_d == ST_SAMPLE) begin
      dut_a_d = vec_d[1];
      dut_b_d = vec_d[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      func_q       <= FUNC_AND;
      vec_q        <= '0;
      settle_q     <= '0;
      dut_a_q      <= 1'b0;
      dut_b_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      func_q       <= func_d;
      vec_q        <= vec_d;
      settle_q     <= settle_d;
      dut_a_q      <= dut_a_d;
      dut_b_q      <= dut_b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      fail_vec_q   <= fail_vec_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  assign dut_a      = dut_a_q;
  assign dut_b      = dut_b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign fail_vec   = fail_vec_q;
  assign fail_valid = fail_valid_q;

endmodule

// File: tb/tb_gate_checker.sv
// Testbench for gate_checker: two instances (SETTLE_CYCLES 1 and 3) each drive
// a bench-modelled gate. Expected run results are queued at start; a monitor
// compares every cycle against the queue front.
module tb_gate_checker;

  typedef struct {
    int e0;
    int err;
    int fv;
    int fval;
    int pass;
  } exp_t;

  localparam int S0 = 1;
  localparam int S1 = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [1:0] func_sel = 2'b00;

  logic [1:0] dut_a_w, dut_b_w, dut_y_w, busy_w, done_w, pass_w, fval_w;
  logic [2:0] err_w [2];
  logic [1:0] fv_w  [2];

  int   gsel [2];
  int   settle [2];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q [2][$];

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // gate codes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 tied 0, 5 tied 1
  function automatic logic gate_fn(input int g, input logic a, input logic b);
    case (g)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return ~(a & b);
      4: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  always_comb begin
    dut_y_w    = '0;
    dut_y_w[0] = gate_fn(gsel[0], dut_a_w[0], dut_b_w[0]);
    dut_y_w[1] = gate_fn(gsel[1], dut_a_w[1], dut_b_w[1]);
  end

  gate_checker #(.SETTLE_CYCLES(S0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .func_sel(func_sel),
    .dut_a(dut_a_w[0]), .dut_b(dut_b_w[0]), .dut_y(dut_y_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_cnt(err_w[0]), .fail_vec(fv_w[0]), .fail_valid(fval_w[0])
  );

  gate_checker #(.SETTLE_CYCLES(S1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .func_sel(func_sel),
    .dut_a(dut_a_w[1]), .dut_b(dut_b_w[1]), .dut_y(dut_y_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_cnt(err_w[1]), .fail_vec(fv_w[1]), .fail_valid(fval_w[1])
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Result of applying all four {a,b} vectors to gate g while expecting f.
  function automatic exp_t make_exp(input int f, input int g, input int e0);
    exp_t e;
    e.e0 = e0; e.err = 0; e.fv = 0; e.fval = 0;
    for (int v = 0; v < 4; v++) begin
      logic a, b;
      a = logic'((v >> 1) & 1);
      b = logic'(v & 1);
      if (gate_fn(g, a, b) != gate_fn(f, a, b)) begin
        if (e.fval == 0) begin
          e.fv = v;
          e.fval = 1;
        end
        e.err++;
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  // Monitor: pins, busy and done are checked every cycle against the
  // position inside the expected run; results are checked on the done cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int   j, n;
      exp_t e;
      n = 4 * (settle[d] + 1);
      if (sb_q[d].size() > 0) j = cyc - sb_q[d][0].e0;
      else j = -1;
      if (sb_q[d].size() == 0 || j < 0) begin
        chk($sformatf("d%0d idle_busy", d), int'(busy_w[d]), 0);
        chk($sformatf("d%0d idle_done", d), int'(done_w[d]), 0);
        chk($sformatf("d%0d idle_pins", d), int'({dut_a_w[d], dut_b_w[d]}), 0);
      end else if (j < n) begin
        chk($sformatf("d%0d run_busy", d), int'(busy_w[d]), 1);
        chk($sformatf("d%0d run_done", d), int'(done_w[d]), 0);
        chk($sformatf("d%0d run_pins", d), int'({dut_a_w[d], dut_b_w[d]}), j / (settle[d] + 1));
      end else begin
        e = sb_q[d].pop_front();
        chk($sformatf("d%0d done", d), int'(done_w[d]), 1);
        chk($sformatf("d%0d done_busy", d), int'(busy_w[d]), 1);
        chk($sformatf("d%0d done_pins", d), int'({dut_a_w[d], dut_b_w[d]}), 0);
        chk($sformatf("d%0d pass", d), int'(pass_w[d]), e.pass);
        chk($sformatf("d%0d err_cnt", d), int'(err_w[d]), e.err);
        chk($sformatf("d%0d fail_valid", d), int'(fval_w[d]), e.fval);
        chk($sformatf("d%0d fail_vec", d), int'(fv_w[d]), e.fv);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d busy", tag, d), int'(busy_w[d]), 0);
      chk($sformatf("%s d%0d done", tag, d), int'(done_w[d]), 0);
      chk($sformatf("%s d%0d pass", tag, d), int'(pass_w[d]), 0);
      chk($sformatf("%s d%0d err_cnt", tag, d), int'(err_w[d]), 0);
      chk($sformatf("%s d%0d fail_vec", tag, d), int'(fv_w[d]), 0);
      chk($sformatf("%s d%0d fail_valid", tag, d), int'(fval_w[d]), 0);
      chk($sformatf("%s d%0d pins", tag, d), int'({dut_a_w[d], dut_b_w[d]}), 0);
    end
  endtask

  task automatic launch(input int f, input int g0, input int g1, output int c);
    @(negedge clk);
    gsel[0]  = g0;
    gsel[1]  = g1;
    func_sel = 2'(f);
    start    = 1'b1;
    c        = cyc;
    sb_q[0].push_back(make_exp(f, g0, c + 1));
    sb_q[1].push_back(make_exp(f, g1, c + 1));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sb_q[0].size() + sb_q[1].size()) > 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle_timeout", (k >= 400) ? 1 : 0, 0);
    sb_q[0].delete();
    sb_q[1].delete();
    @(negedge clk);
  endtask

  task automatic run(input int f, input int g0, input int g1);
    int c;
    launch(f, g0, g1, c);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    int c;
    settle[0] = S0;
    settle[1] = S1;
    gsel[0] = 0;
    gsel[1] = 0;

    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    run(0, 0, 0);   // real AND, expect AND
    run(1, 0, 0);   // AND gate, expect OR
    run(0, 5, 5);   // tied 1, expect AND
    run(3, 5, 5);   // tied 1, expect NAND
    run(3, 4, 0);   // tied 0 vs NAND: every vector except 11

    // start and func_sel changes mid-run are ignored
    launch(0, 0, 0, c);
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    func_sel = 2'b10;
    start    = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle();

    // start held high: each instance restarts on the IDLE cycle after DONE
    launch(2, 2, 1, c);
    sb_q[0].push_back(make_exp(2, 2, c + 1 + 4 * (S0 + 1) + 2));
    sb_q[1].push_back(make_exp(2, 1, c + 1 + 4 * (S1 + 1) + 2));
    repeat (4 * (S1 + 1) + 3) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // asynchronous reset while instance 0 applies vector 2
    launch(1, 0, 0, c);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    sb_q[0].delete();
    sb_q[1].delete();
    #1 check_all_zero("midrun_reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run(1, 1, 0);

    for (int i = 0; i < 16; i++) begin
      run(int'($urandom_range(3, 0)), int'($urandom_range(5, 0)),
          int'($urandom_range(5, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
